// File: rtl/mem_bus_decoder.sv
// CPU-to-slave memory bus decoder: address match, exec permission check,
// single outstanding access with timeout, and error reporting.
module mem_bus_decoder #(
  parameter int                       N_SLAVES   = 3,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE = {32'h10000000, 32'h00001000, 32'h00000000},
  parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK = {32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFF000},
  parameter logic [N_SLAVES-1:0]      SLAVE_EXEC = 3'b001,
  parameter int                       TIMEOUT    = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     cpu_valid,
  input  logic                     cpu_instr,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic [N_SLAVES-1:0]      slv_enable,
  output logic                     slv_write,
  output logic [3:0]               slv_wstrb,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  input  logic [N_SLAVES-1:0]      slv_ready,
  input  logic [N_SLAVES*32-1:0]   slv_rdata,
  output logic                     bus_error,
  output logic [31:0]              err_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t                state_reg, state_next;
  logic [N_SLAVES-1:0]   slv_enable_reg, slv_enable_next;
  logic                  slv_write_reg, slv_write_next;
  logic [3:0]            slv_wstrb_reg, slv_wstrb_next;
  logic [31:0]           slv_addr_reg, slv_addr_next;
  logic [31:0]           slv_wdata_reg, slv_wdata_next;
  logic [31:0]           req_addr_reg, req_addr_next;
  logic [31:0]           cpu_rdata_reg, cpu_rdata_next;
  logic [31:0]           err_addr_reg, err_addr_next;
  logic [15:0]           cnt_reg, cnt_next;

  logic [N_SLAVES-1:0]   match;
  logic [N_SLAVES-1:0]   grant;
  logic                  found;
  logic [31:0]           mask_sel;
  logic                  sel_exec;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
    assign match[gi] = (cpu_addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32];
  end

  // Lowest-index match wins when address windows overlap.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    mask_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (match[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        mask_sel = SLAVE_MASK[i*32 +: 32];
      end
    end
  end

  assign sel_exec  = |(grant & SLAVE_EXEC);
  assign sel_ready = |(slv_ready & slv_enable_reg);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (slv_enable_reg[i]) sel_rdata = sel_rdata | slv_rdata[i*32 +: 32];
    end
  end

  always_comb begin
    state_next      = state_reg;
    slv_enable_next = slv_enable_reg;
    slv_write_next  = slv_write_reg;
    slv_wstrb_next  = slv_wstrb_reg;
    slv_addr_next   = slv_addr_reg;
    slv_wdata_next  = slv_wdata_reg;
    req_addr_next   = req_addr_reg;
    cpu_rdata_next  = cpu_rdata_reg;
    err_addr_next   = err_addr_reg;
    cnt_next        = cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (cpu_valid) begin
          if (found && (!cpu_instr || sel_exec)) begin
            state_next      = ACCESS;
            slv_enable_next = grant;
            slv_addr_next   = cpu_addr & ~mask_sel;
            slv_wdata_next  = cpu_wdata;
            slv_wstrb_next  = cpu_wstrb;
            slv_write_next  = |cpu_wstrb;
            req_addr_next   = cpu_addr;
            cnt_next        = '0;
          end else begin
            state_next     = ERR;
            err_addr_next  = cpu_addr;
            cpu_rdata_next = '0;
          end
        end
      end
      ACCESS: begin
        // A ready in the final allowed cycle takes priority over the timeout.
        if (sel_ready) begin
          state_next      = RESP;
          slv_enable_next = '0;
          cpu_rdata_next  = slv_write_reg ? 32'h0 : sel_rdata;
        end else if (cnt_reg == 16'(TIMEOUT - 1)) begin
          state_next      = ERR;
          slv_enable_next = '0;
          err_addr_next   = req_addr_reg;
          cpu_rdata_next  = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg      <= IDLE;
      slv_enable_reg <= '0;
      slv_write_reg  <= 1'b0;
      slv_wstrb_reg  <= '0;
      slv_addr_reg   <= '0;
      slv_wdata_reg  <= '0;
      req_addr_reg   <= '0;
      cpu_rdata_reg  <= '0;
      err_addr_reg   <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      slv_enable_reg <= slv_enable_next;
      slv_write_reg  <= slv_write_next;
      slv_wstrb_reg  <= slv_wstrb_next;
      slv_addr_reg   <= slv_addr_next;
      slv_wdata_reg  <= slv_wdata_next;
      req_addr_reg   <= req_addr_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      err_addr_reg   <= err_addr_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign cpu_ready  = (state_reg == RESP) || (state_reg == ERR);
  assign bus_error  = (state_reg == ERR);
  assign cpu_rdata  = cpu_rdata_reg;
  assign err_addr   = err_addr_reg;
  assign slv_enable = slv_enable_reg;
  assign slv_write  = slv_write_reg;
  assign slv_wstrb  = slv_wstrb_reg;
  assign slv_addr   = slv_addr_reg;
  assign slv_wdata  = slv_wdata_reg;

endmodule
